// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: three-channel PWM generator for the RGB LED current driver.
// It accepts a target colour over valid/ready and either jumps straight to it
// or fades each channel one LSB per fade step. New duties are latched only at
// PWM period boundaries, so a period in progress is never cut short.
// Optional build macro RGB_PWM_GAMMA_EN inserts a quadratic gamma map between
// the current colour and the PWM comparator.
module rgb_pwm_fader #(
    parameter int PWM_W    = 8,
    parameter int PRESCALE = 4,
    parameter int FADE_DIV = 65536
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PWM_W-1:0] cfg_r,
    input  logic [PWM_W-1:0] cfg_g,
    input  logic [PWM_W-1:0] cfg_b,
    input  logic             cfg_fade,
    output logic             busy,
    output logic             pwm_red,
    output logic             pwm_green,
    output logic             pwm_blue
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FD_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
    localparam logic [FD_W-1:0]  FD_MAX  = FD_W'(FADE_DIV - 1);
    localparam logic [FD_W-1:0]  FD_ONE  = FD_W'(1);
    localparam logic [PWM_W-1:0] CNT_MAX = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] CNT_ONE = PWM_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FADE = 1'b1
    } state_e;

    state_e           state_q;
    logic [PS_W-1:0]  presc_q;
    logic [PWM_W-1:0] pwm_cnt_q;
    logic [FD_W-1:0]  fade_tmr_q;
    logic [PWM_W-1:0] cur_r_q, cur_g_q, cur_b_q;
    logic [PWM_W-1:0] tgt_r_q, tgt_g_q, tgt_b_q;
    logic [PWM_W-1:0] act_r_q, act_g_q, act_b_q;
    logic [PWM_W-1:0] cur_r_d, cur_g_d, cur_b_d;
    logic             busy_q, cfg_ready_q;
    logic             pwm_red_q, pwm_green_q, pwm_blue_q;
    logic             tick_s, period_end_s, fade_wrap_s, fade_done_s;

    // Move one LSB toward the target; saturates naturally because it never passes tgt.
    function automatic logic [PWM_W-1:0] step_toward(input logic [PWM_W-1:0] cur,
                                                     input logic [PWM_W-1:0] tgt);
        if (cur < tgt) begin
            return cur + CNT_ONE;
        end else if (cur > tgt) begin
            return cur - CNT_ONE;
        end else begin
            return cur;
        end
    endfunction

    // Colour-to-duty map: identity, or rounded-up square law when gamma is built in.
    function automatic logic [PWM_W-1:0] duty_map(input logic [PWM_W-1:0] c);
`ifdef RGB_PWM_GAMMA_EN
        logic [2*PWM_W-1:0] sq;
        sq = ({{PWM_W{1'b0}}, c} * {{PWM_W{1'b0}}, c}) + {{PWM_W{1'b0}}, CNT_MAX};
        return sq[2*PWM_W-1:PWM_W];
`else
        return c;
`endif
    endfunction

    // Timing strobes and next colour for a fade step.
    always_comb begin
        tick_s       = (presc_q == PS_MAX);
        period_end_s = tick_s && (pwm_cnt_q == CNT_MAX);
        fade_wrap_s  = (fade_tmr_q == FD_MAX);
        cur_r_d      = step_toward(cur_r_q, tgt_r_q);
        cur_g_d      = step_toward(cur_g_q, tgt_g_q);
        cur_b_d      = step_toward(cur_b_q, tgt_b_q);
        fade_done_s  = (cur_r_d == tgt_r_q) && (cur_g_d == tgt_g_q) && (cur_b_d == tgt_b_q);
    end

    // Prescaler and free-running PWM period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else if (tick_s) begin
            presc_q   <= '0;
            pwm_cnt_q <= pwm_cnt_q + CNT_ONE;
        end else begin
            presc_q   <= presc_q + PS_ONE;
        end
    end

    // Request handshake, fade stepping and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fade_tmr_q  <= '0;
            cur_r_q     <= '0;
            cur_g_q     <= '0;
            cur_b_q     <= '0;
            tgt_r_q     <= '0;
            tgt_g_q     <= '0;
            tgt_b_q     <= '0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready_q) begin
                        tgt_r_q <= cfg_r;
                        tgt_g_q <= cfg_g;
                        tgt_b_q <= cfg_b;
                        if (!cfg_fade) begin
                            cur_r_q <= cfg_r;
                            cur_g_q <= cfg_g;
                            cur_b_q <= cfg_b;
                        end else if ({cfg_r, cfg_g, cfg_b} != {cur_r_q, cur_g_q, cur_b_q}) begin
                            state_q     <= ST_FADE;
                            fade_tmr_q  <= '0;
                            busy_q      <= 1'b1;
                            cfg_ready_q <= 1'b0;
                        end else begin
                            state_q     <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FADE: begin
                    if (fade_wrap_s) begin
                        fade_tmr_q <= '0;
                        cur_r_q    <= cur_r_d;
                        cur_g_q    <= cur_g_d;
                        cur_b_q    <= cur_b_d;
                        if (fade_done_s) begin
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                            cfg_ready_q <= 1'b1;
                        end else begin
                            state_q     <= ST_FADE;
                        end
                    end else begin
                        fade_tmr_q <= fade_tmr_q + FD_ONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Latch duties at period end (pre-step colour) and drive the registered pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_r_q     <= '0;
            act_g_q     <= '0;
            act_b_q     <= '0;
            pwm_red_q   <= 1'b0;
            pwm_green_q <= 1'b0;
            pwm_blue_q  <= 1'b0;
        end else begin
            if (period_end_s) begin
                act_r_q <= duty_map(cur_r_q);
                act_g_q <= duty_map(cur_g_q);
                act_b_q <= duty_map(cur_b_q);
            end
            pwm_red_q   <= (pwm_cnt_q < act_r_q);
            pwm_green_q <= (pwm_cnt_q < act_g_q);
            pwm_blue_q  <= (pwm_cnt_q < act_b_q);
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign pwm_red   = pwm_red_q;
    assign pwm_green = pwm_green_q;
    assign pwm_blue  = pwm_blue_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader with PWM_W=8, PRESCALE=1, FADE_DIV=4.
`timescale 1ns/1ps
module tb_rgb_pwm_fader;

    localparam int PWM_W    = 8;
    localparam int PRESCALE = 1;
    localparam int FADE_DIV = 4;
    localparam int PERIOD   = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_fade = 1'b0;
    logic [7:0] cfg_r = 8'd0;
    logic [7:0] cfg_g = 8'd0;
    logic [7:0] cfg_b = 8'd0;
    logic       cfg_ready, busy, pwm_red, pwm_green, pwm_blue;

    int checks = 0;
    int errors = 0;

    // Free-running period phase: equals the DUT period counter after each edge.
    logic [7:0] phase_q;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         er;
        int         eg;
        int         eb;
    } vec_t;

    vec_t vecs[4];

    rgb_pwm_fader #(
        .PWM_W   (PWM_W),
        .PRESCALE(PRESCALE),
        .FADE_DIV(FADE_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_r    (cfg_r),
        .cfg_g    (cfg_g),
        .cfg_b    (cfg_b),
        .cfg_fade (cfg_fade),
        .busy     (busy),
        .pwm_red  (pwm_red),
        .pwm_green(pwm_green),
        .pwm_blue (pwm_blue)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= 8'd0;
        else        phase_q <= phase_q + 8'd1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int duty(input int c);
`ifdef RGB_PWM_GAMMA_EN
        return (c * c + 255) >> 8;
`else
        return c;
`endif
    endfunction

    // Present one request at a negedge while ready; returns 1 ns after the accept edge.
    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic fade);
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) check("send_ready_timeout", 0, 1);
        cfg_r = r; cfg_g = g; cfg_b = b; cfg_fade = fade; cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    // Count high samples over one aligned period, at least half a period after the call.
    task automatic measure(output int hr, output int hg, output int hb);
        int n;
        n = 0; hr = 0; hg = 0; hb = 0;
        @(negedge clk);
        while (phase_q != 8'd128 && n < 600) begin @(negedge clk); n++; end
        while (phase_q != 8'd1 && n < 600) begin @(negedge clk); n++; end
        if (n >= 600) check("measure_sync_timeout", 0, 1);
        for (int i = 0; i < PERIOD; i++) begin
            hr += int'(pwm_red);
            hg += int'(pwm_green);
            hb += int'(pwm_blue);
            @(negedge clk);
        end
    endtask

    initial begin
        int hr, hg, hb, hi;

`ifdef RGB_PWM_GAMMA_EN
        vecs[0] = '{r: 8'd64,  g: 8'd0,   b: 8'd255, er: 16,  eg: 0,   eb: 255};
        vecs[1] = '{r: 8'd128, g: 8'd1,   b: 8'd200, er: 64,  eg: 1,   eb: 157};
        vecs[2] = '{r: 8'd1,   g: 8'd254, b: 8'd32,  er: 1,   eg: 253, eb: 4};
        vecs[3] = '{r: 8'd255, g: 8'd255, b: 8'd255, er: 255, eg: 255, eb: 255};
`else
        vecs[0] = '{r: 8'd64,  g: 8'd0,   b: 8'd255, er: 64,  eg: 0,   eb: 255};
        vecs[1] = '{r: 8'd128, g: 8'd1,   b: 8'd200, er: 128, eg: 1,   eb: 200};
        vecs[2] = '{r: 8'd1,   g: 8'd254, b: 8'd32,  er: 1,   eg: 254, eb: 32};
        vecs[3] = '{r: 8'd255, g: 8'd255, b: 8'd255, er: 255, eg: 255, eb: 255};
`endif

        // Reset: held for 5 clocks, then 3 silent periods.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_pwm_red", int'(pwm_red), 0);
        check("rst_pwm_green", int'(pwm_green), 0);
        check("rst_pwm_blue", int'(pwm_blue), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(cfg_ready), 1);
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            hi += int'(pwm_red) + int'(pwm_green) + int'(pwm_blue);
        end
        check("rst_quiet_3_periods", hi, 0);
        check("post_rst_ready", int'(cfg_ready), 1);

        // Jump table; first entry also proves the period in progress is untouched.
        for (int v = 0; v < 4; v++) begin
            send(vecs[v].r, vecs[v].g, vecs[v].b, 1'b0);
            if (v == 0) begin
                hi = 0;
                for (int k = 0; k < 300; k++) begin
                    @(negedge clk);
                    hi += int'(pwm_red) + int'(pwm_blue);
                    if (phase_q == 8'd0) break;
                end
                check("jump_no_mid_period_change", hi, 0);
            end
            measure(hr, hg, hb);
            check($sformatf("jump%0d_red", v), hr, vecs[v].er);
            check($sformatf("jump%0d_green", v), hg, vecs[v].eg);
            check($sformatf("jump%0d_blue", v), hb, vecs[v].eb);
        end

        // Fade up from black to r=3: one step every 4 clocks.
        send(8'd0, 8'd0, 8'd0, 1'b0);
        send(8'd3, 8'd0, 8'd0, 1'b1);
        check("fadeup_busy_start", int'(busy), 1);
        check("fadeup_ready_start", int'(cfg_ready), 0);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i % 4 == 0) check($sformatf("fadeup_cur_r_step%0d", i / 4), int'(dut.cur_r_q), i / 4);
            if (i == 11) check("fadeup_busy_before_end", int'(busy), 1);
        end
        check("fadeup_busy_end", int'(busy), 0);
        check("fadeup_ready_end", int'(cfg_ready), 1);
        measure(hr, hg, hb);
        check("fadeup_red_duty", hr, duty(3));

        // Mixed fade: red down, green up, blue constant.
        send(8'd2, 8'd0, 8'd5, 1'b0);
        send(8'd0, 8'd2, 8'd5, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                check("mixed_r_step1", int'(dut.cur_r_q), 1);
                check("mixed_g_step1", int'(dut.cur_g_q), 1);
                check("mixed_b_step1", int'(dut.cur_b_q), 5);
            end
        end
        check("mixed_busy_end", int'(busy), 0);
        repeat (8) @(posedge clk);
        #1;
        check("mixed_r_no_undershoot", int'(dut.cur_r_q), 0);
        check("mixed_g_no_overshoot", int'(dut.cur_g_q), 2);
        measure(hr, hg, hb);
        check("mixed_red_duty", hr, duty(0));
        check("mixed_green_duty", hg, duty(2));
        check("mixed_blue_duty", hb, duty(5));

        // Fade request equal to current colour: accepted, no fade.
        send(8'd0, 8'd2, 8'd5, 1'b1);
        check("same_target_busy", int'(busy), 0);
        check("same_target_ready", int'(cfg_ready), 1);

        // Back-pressure: a request held during a 4-step fade waits for ready.
        send(8'd4, 8'd2, 8'd5, 1'b1);
        cfg_r = 8'd9; cfg_g = 8'd9; cfg_b = 8'd9; cfg_fade = 1'b0; cfg_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            if (i == 8) begin
                check("bp_ready_low", int'(cfg_ready), 0);
                check("bp_cur_r_mid", int'(dut.cur_r_q), 2);
            end
            if (i == 16) begin
                check("bp_ready_back", int'(cfg_ready), 1);
                check("bp_cur_r_done", int'(dut.cur_r_q), 4);
            end
        end
        cfg_valid = 1'b0;
        check("bp_accepted_r", int'(dut.cur_r_q), 9);
        check("bp_accepted_g", int'(dut.cur_g_q), 9);

        // Reset pulse in the middle of a fade.
        send(8'd0, 8'd0, 8'd0, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        check("midfade_busy_before_rst", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midfade_rst_pwm", int'(pwm_red) + int'(pwm_green) + int'(pwm_blue), 0);
        check("midfade_rst_busy", int'(busy), 0);
        check("midfade_rst_ready", int'(cfg_ready), 1);
        check("midfade_rst_cur_r", int'(dut.cur_r_q), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            hi += int'(pwm_red) + int'(pwm_green) + int'(pwm_blue);
        end
        check("post_midfade_rst_quiet", hi, 0);
        check("post_midfade_rst_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
